color_sequencer: RTL and testbench
==================================

Name: color_sequencer

Overview:
- Controller that owns the display colour index and steps it through a configurable range (lo..hi), dwelling a programmable number of step ticks on each value.
- Accepts one-shot override requests from a second source via a valid/ready handshake. The sequence is suspended during an override and resumes exactly where it left off.
- Sits between the game/UI control logic and the pixel colour path; it replaces free-running colour counters.

Parameters:
- CW, 4, colour index width.
- DWELL_W, 8, dwell counter width.
- DEFAULT_LO, 2, reset lower bound of the range.
- DEFAULT_HI, 5, reset upper bound of the range.
- DEFAULT_DWELL, 2, reset ticks per colour.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- tick  in  1  step enable; dwell counts only on cycles where tick=1.
- start  in  1  begin sequencing (level or pulse).
- stop  in  1  halt sequencing.
- cfg_we  in  1  configuration write strobe.
- cfg_lo  in  CW  new lower bound.
- cfg_hi  in  CW  new upper bound.
- cfg_dwell  in  DWELL_W  new dwell count.
- cfg_err  out  1  one-cycle pulse when a config write is rejected.
- ovr_valid  in  1  override request.
- ovr_color  in  CW  override colour, sampled on accept.
- ovr_ready  out  1  override can be accepted this cycle.
- color  out  CW  current colour index, registered.
- running  out  1  high in RUN or OVR.
- wrap  out  1  one-cycle pulse on the hi->lo transition.

Behaviour:
- Reset state:
  - state=IDLE; color=DEFAULT_LO; lo/hi/dwell=defaults; dwell_cnt=0.
  - cfg_err=0, wrap=0, running=0, ovr_ready=0.
- States and ovr_ready:
  - States are IDLE, RUN, OVR.
  - ovr_ready is decoded combinationally from the state register: 1 only when state=RUN.
- Priority, highest first: rst, stop, override accept, tick, start.
- stop: from any state, go to IDLE on the next cycle. color holds its current value and dwell_cnt is cleared. start and stop in the same cycle: stop wins.
- IDLE:
  - start=1 -> RUN next cycle with color=lo and dwell_cnt=0.
  - cfg_we=1 -> if cfg_lo<=cfg_hi, load lo, hi and dwell next cycle; otherwise ignore the write and pulse cfg_err for one cycle.
  - cfg_dwell=0 is stored as-is and treated as 1.
  - color does not change on a config write.
- cfg_we outside IDLE is ignored with no cfg_err.
- RUN:
  - Each tick increments dwell_cnt.
  - On the tick where dwell_cnt==eff_dwell-1: dwell_cnt<=0, and color<=color+1, or color<=lo if color>=hi.
  - On that wrap, wrap=1 in the same cycle color updates.
  - start in RUN is ignored.
- Override accept (ovr_valid & ovr_ready):
  - Next cycle: state=OVR, color=ovr_color; the current color and dwell_cnt are saved; the override dwell counter is cleared.
  - A tick in the accept cycle is not counted toward RUN.
- OVR:
  - Counts ticks. After eff_dwell ticks, the next cycle restores the saved color and dwell_cnt and returns to RUN.
  - No wrap pulses in OVR. ovr_valid is ignored; ovr_ready=0.
- Arithmetic: colour increment is CW-bit and never exceeds hi. The dwell compare uses DWELL_W bits.
- Latency:
  - Every control input takes effect on the next clk edge.
  - With tick tied high and dwell=2, each colour is held for 2 cycles.

Optional Feature:
- Macro: COLOR_PINGPONG_EN.
- Defined:
  - A direction bit (reset: up) is added. At hi the direction reverses to down; at lo it reverses to up.
  - wrap pulses at each reversal.
  - lo==hi holds a constant colour with no wrap.
  - The direction bit is saved and restored across an override. start resets the direction to up.
- Undefined: wrap-around behaviour exactly as in Behaviour.

Test Plan:
- Reset defaults, tick=1, start pulse -> color sequence 2,2,3,3,4,4,5,5,2,...; wrap=1 only in the cycle color goes 5->2.
- In IDLE, write cfg lo=7 hi=3 -> cfg_err pulses once; then lo=1 hi=3 dwell=0 and start -> color 1,2,3,1 changing every tick.
- RUN at color=4 with dwell_cnt=1, ovr_valid with ovr_color=9 -> ovr_ready=1, color=9 for 2 ticks, then color=4 with dwell_cnt=1, next tick -> 5.
- start and stop asserted together in IDLE -> state stays IDLE; stop in OVR -> IDLE, color frozen at the override value, running=0.
- tick gapped (1 of every 3 cycles) -> colour changes only after 2 counted ticks; cfg_we during RUN -> no change, no cfg_err.
- COLOR_PINGPONG_EN with lo=2 hi=4 dwell=1 -> 2,3,4,3,2,3; wrap pulses on arrival at 4 and at 2.

Source files
------------

// File: rtl/color_sequencer.sv
// color_sequencer: owns the display colour index and steps it through lo..hi,
// holding each value for a programmable number of step ticks. A second source
// can inject a one-shot override colour through a valid/ready handshake; the
// running sequence is parked during the override and resumes where it stopped.
// Optional build macro COLOR_PINGPONG_EN: bounce between lo and hi instead of
// wrapping from hi back to lo.
module color_sequencer #(
  parameter int CW            = 4,
  parameter int DWELL_W       = 8,
  parameter int DEFAULT_LO    = 2,
  parameter int DEFAULT_HI    = 5,
  parameter int DEFAULT_DWELL = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               stop,
  input  logic               cfg_we,
  input  logic [CW-1:0]      cfg_lo,
  input  logic [CW-1:0]      cfg_hi,
  input  logic [DWELL_W-1:0] cfg_dwell,
  output logic               cfg_err,
  input  logic               ovr_valid,
  input  logic [CW-1:0]      ovr_color,
  output logic               ovr_ready,
  output logic [CW-1:0]      color,
  output logic               running,
  output logic               wrap
);

  typedef enum logic [1:0] {IDLE, RUN, OVR} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      lo, hi, saved_color, step_color;
  logic [DWELL_W-1:0] dwell, dwell_cnt, saved_cnt, ovr_cnt, last_cnt;
  logic               cfg_err_r, wrap_r, step_wrap;
  logic               accept, run_last, ovr_last;
`ifdef COLOR_PINGPONG_EN
  logic               dir, saved_dir, step_dir;
`endif

  // A stored dwell of 0 behaves like 1, so the final count index is 0 either way.
  assign last_cnt = (dwell == '0) ? '0 : dwell - 1'b1;
  assign accept   = (state == RUN) && ovr_valid && !stop;
  assign run_last = tick && (dwell_cnt == last_cnt);
  assign ovr_last = tick && (ovr_cnt == last_cnt);

  assign ovr_ready = (state == RUN);
  assign running   = (state != IDLE);
  assign cfg_err   = cfg_err_r;
  assign wrap      = wrap_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; stop overrides every other request.
  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start)    state_nxt = RUN;
        RUN:     if (accept)   state_nxt = OVR;
        OVR:     if (ovr_last) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Colour that follows the current one at the end of a dwell period.
`ifdef COLOR_PINGPONG_EN
  always_comb begin
    step_color = color;
    step_wrap  = 1'b0;
    step_dir   = dir;
    if (lo == hi) begin
      step_color = lo;
    end else if (dir) begin
      if (color >= hi) begin
        step_color = color - 1'b1;
        step_dir   = 1'b0;
      end else begin
        step_color = color + 1'b1;
        if (step_color == hi) begin
          step_wrap = 1'b1;
          step_dir  = 1'b0;
        end
      end
    end else begin
      if (color <= lo) begin
        step_color = color + 1'b1;
        step_dir   = 1'b1;
      end else begin
        step_color = color - 1'b1;
        if (step_color == lo) begin
          step_wrap = 1'b1;
          step_dir  = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    step_color = color + 1'b1;
    step_wrap  = 1'b0;
    if (color >= hi) begin
      step_color = lo;
      step_wrap  = 1'b1;
    end
  end
`endif

  // Colour, configuration, dwell counters and the override save slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      color     <= CW'(DEFAULT_LO);
      lo        <= CW'(DEFAULT_LO);
      hi        <= CW'(DEFAULT_HI);
      dwell     <= DWELL_W'(DEFAULT_DWELL);
      dwell_cnt <= '0;
      ovr_cnt   <= '0;
      cfg_err_r <= 1'b0;
      wrap_r    <= 1'b0;
`ifdef COLOR_PINGPONG_EN
      dir       <= 1'b1;
`endif
    end else begin
      cfg_err_r <= 1'b0;
      wrap_r    <= 1'b0;
      if (stop) begin
        dwell_cnt <= '0;
        ovr_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              color     <= lo;
              dwell_cnt <= '0;
`ifdef COLOR_PINGPONG_EN
              dir       <= 1'b1;
`endif
            end
            if (cfg_we) begin
              if (cfg_lo <= cfg_hi) begin
                lo    <= cfg_lo;
                hi    <= cfg_hi;
                dwell <= cfg_dwell;
              end else begin
                cfg_err_r <= 1'b1;
              end
            end
          end
          RUN: begin
            if (accept) begin
              saved_color <= color;
              saved_cnt   <= dwell_cnt;
`ifdef COLOR_PINGPONG_EN
              saved_dir   <= dir;
`endif
              color       <= ovr_color;
              ovr_cnt     <= '0;
            end else if (tick) begin
              if (run_last) begin
                dwell_cnt <= '0;
                color     <= step_color;
                wrap_r    <= step_wrap;
`ifdef COLOR_PINGPONG_EN
                dir       <= step_dir;
`endif
              end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
              end
            end
          end
          OVR: begin
            if (tick) begin
              if (ovr_last) begin
                color     <= saved_color;
                dwell_cnt <= saved_cnt;
                ovr_cnt   <= '0;
`ifdef COLOR_PINGPONG_EN
                dir       <= saved_dir;
`endif
              end else begin
                ovr_cnt <= ovr_cnt + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_color_sequencer.sv
// Directed bench for color_sequencer (default build, wrap-around mode).
module tb_color_sequencer;

  logic       clk = 1'b0;
  logic       rst, tick, start, stop, cfg_we;
  logic [3:0] cfg_lo, cfg_hi;
  logic [7:0] cfg_dwell;
  logic       cfg_err;
  logic       ovr_valid;
  logic [3:0] ovr_color;
  logic       ovr_ready;
  logic [3:0] color;
  logic       running, wrap;

  int n_chk  = 0;
  int n_fail = 0;

  color_sequencer dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .cfg_we(cfg_we), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_dwell(cfg_dwell),
    .cfg_err(cfg_err), .ovr_valid(ovr_valid), .ovr_color(ovr_color),
    .ovr_ready(ovr_ready), .color(color), .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int l, input int h, input int d);
    cfg_we = 1'b1; cfg_lo = 4'(l); cfg_hi = 4'(h); cfg_dwell = 8'(d);
    step();
    cfg_we = 1'b0;
  endtask

  int seq1  [11] = '{2, 2, 3, 3, 4, 4, 5, 5, 2, 2, 3};
  int wrap1 [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  int seq2  [6]  = '{1, 2, 3, 1, 2, 3};
  int wrap2 [6]  = '{0, 0, 0, 1, 0, 0};
  int seq5  [12] = '{2, 2, 2, 3, 3, 3, 3, 3, 3, 4, 4, 4};

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
    cfg_lo = '0; cfg_hi = '0; cfg_dwell = '0; ovr_valid = 1'b0; ovr_color = '0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_color", color, 2);
    check("rst_running", running, 0);
    check("rst_ovr_ready", ovr_ready, 0);
    check("rst_wrap", wrap, 0);
    check("rst_cfg_err", cfg_err, 0);

    // Default range, dwell 2, tick held high
    tick = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    check("run_running", running, 1);
    check("run_ovr_ready", ovr_ready, 1);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("seq1_color[%0d]", i), color, seq1[i]);
      check($sformatf("seq1_wrap[%0d]", i), wrap, wrap1[i]);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_running", running, 0);
    check("stop_color_hold", color, 3);

    // Rejected and accepted configuration writes in IDLE
    do_cfg(7, 3, 2);
    check("cfg_bad_err", cfg_err, 1);
    step();
    check("cfg_err_pulse", cfg_err, 0);
    do_cfg(1, 3, 0);
    check("cfg_ok_err", cfg_err, 0);
    check("cfg_color_hold", color, 3);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("seq2_color[%0d]", i), color, seq2[i]);
      check($sformatf("seq2_wrap[%0d]", i), wrap, wrap2[i]);
      // Configuration writes while running must be ignored silently.
      cfg_we = (i == 1); cfg_lo = 4'd9; cfg_hi = 4'd0; cfg_dwell = 8'd5;
      step();
      cfg_we = 1'b0;
      check($sformatf("run_cfg_err[%0d]", i), cfg_err, 0);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    do_cfg(2, 5, 2);

    // Override in the middle of a dwell
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check("pre_ovr_color", color, 4);
    check("pre_ovr_ready", ovr_ready, 1);
    ovr_valid = 1'b1; ovr_color = 4'd9;
    step();
    ovr_valid = 1'b0;
    check("ovr_color0", color, 9);
    check("ovr_ready_in_ovr", ovr_ready, 0);
    check("ovr_running", running, 1);
    step();
    check("ovr_color1", color, 9);
    step();
    check("ovr_restore", color, 4);
    check("ovr_restore_ready", ovr_ready, 1);
    step();
    check("ovr_resume", color, 5);
    check("ovr_resume_wrap", wrap, 0);

    // Stop during an override, then start+stop together in IDLE
    ovr_valid = 1'b1; ovr_color = 4'd11;
    step();
    ovr_valid = 1'b0;
    check("ovr2_color", color, 11);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("ovr_stop_running", running, 0);
    check("ovr_stop_color", color, 11);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("start_stop_running", running, 0);
    check("start_stop_color", color, 11);

    // Gapped tick: one tick every three cycles
    tick = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick = (k % 3 == 0);
      step();
      check($sformatf("gap_color[%0d]", k), color, seq5[k]);
    end
    tick = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
